// File: rtl/y86_pkg.sv
// Shared types and constants for the Y86-64 write-back slice: instruction codes,
// status codes, register IDs, processor state and the W pipeline register layout.
package y86_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 15;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        CPU_RUN    = 2'd0,
        CPU_HALTED = 2'd1,
        CPU_FAULT  = 2'd2
    } cpu_state_e;

    typedef struct packed {
        logic            valid;
        logic [2:0]      stat;
        logic [3:0]      icode;
        logic [3:0]      dstE;
        logic [XLEN-1:0] valE;
        logic [3:0]      dstM;
        logic [XLEN-1:0] valM;
    } w_reg_t;

    localparam w_reg_t W_BUBBLE = '{
        valid: 1'b0, stat: STAT_AOK, icode: INOP,
        dstE: RNONE, valE: '0, dstM: RNONE, valM: '0
    };

    // IDs at or above NREG (including RNONE) name no architectural register.
    function automatic logic is_reg(input logic [3:0] id);
        return id < 4'(NREG);
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// 15 x 64-bit architectural register file: two write ports (M beats E on the
// same register) and two combinational read ports; out-of-range IDs read as 0.
module y86_regfile
    import y86_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we_e,
    input  logic [3:0]      dst_e,
    input  logic [XLEN-1:0] val_e,
    input  logic            we_m,
    input  logic [3:0]      dst_m,
    input  logic [XLEN-1:0] val_m,
    input  logic [3:0]      src_a,
    input  logic [3:0]      src_b,
    output logic [XLEN-1:0] rd_a,
    output logic [XLEN-1:0] rd_b,
    output logic [XLEN-1:0] rsp
);

    logic [XLEN-1:0] regs_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (we_m && dst_m == 4'(i))
                    regs_q[i] <= val_m;
                else if (we_e && dst_e == 4'(i))
                    regs_q[i] <= val_e;
            end
        end
    end

    assign rd_a = is_reg(src_a) ? regs_q[src_a] : '0;
    assign rd_b = is_reg(src_b) ? regs_q[src_b] : '0;
    assign rsp  = regs_q[RRSP];

endmodule

// File: rtl/y86_writeback.sv
// Y86-64 write-back stage: W pipeline register, register-file commit, run/halt/fault
// status and retire counter. Define WB_BYPASS_EN to forward the committing W values to decode reads.
module y86_writeback
    import y86_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m_valid,
    input  logic [2:0]      m_stat,
    input  logic [3:0]      m_icode,
    input  logic [3:0]      m_dstE,
    input  logic [XLEN-1:0] m_valE,
    input  logic [3:0]      m_dstM,
    input  logic [XLEN-1:0] m_valM,
    input  logic            w_stall,
    input  logic            w_bubble,
    input  logic [3:0]      srcA,
    input  logic [3:0]      srcB,
    output logic [XLEN-1:0] rd_valA,
    output logic [XLEN-1:0] rd_valB,
    output logic [2:0]      wb_stat,
    output logic [1:0]      cpu_state,
    output logic [31:0]     retired_cnt,
    output logic [XLEN-1:0] reg_rsp
);

    w_reg_t          w_q, w_d;
    cpu_state_e      state_q, state_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            run, commit, w_excp;
    logic [XLEN-1:0] arr_a, arr_b;

    assign run    = (state_q == CPU_RUN);
    assign commit = run && w_q.valid && (w_q.stat == STAT_AOK);
    assign w_excp = run && w_q.valid && (w_q.stat != STAT_AOK);

    // Status FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= CPU_RUN;
        else        state_q <= state_d;
    end

    // Status FSM: next state; HALTED/FAULT are absorbing until reset
    always_comb begin
        state_d = state_q;
        if (w_excp)
            state_d = (w_q.stat == STAT_HLT) ? CPU_HALTED : CPU_FAULT;
    end

    // Status FSM: outputs
    always_comb begin
        cpu_state = state_q;
    end

    // An excepting entry stays in W so wb_stat keeps reporting its status.
    always_comb begin
        w_d = w_q;
        if (run && !w_excp && !w_stall) begin
            if (w_bubble || !m_valid) begin
                w_d = W_BUBBLE;
            end else begin
                w_d.valid = 1'b1;
                w_d.stat  = m_stat;
                w_d.icode = m_icode;
                w_d.dstE  = m_dstE;
                w_d.valE  = m_valE;
                w_d.dstM  = m_dstM;
                w_d.valM  = m_valM;
            end
        end
    end

    assign cnt_d = cnt_q + 32'(commit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q   <= W_BUBBLE;
            cnt_q <= '0;
        end else begin
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

    y86_regfile u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we_e  (commit),
        .dst_e (w_q.dstE),
        .val_e (w_q.valE),
        .we_m  (commit),
        .dst_m (w_q.dstM),
        .val_m (w_q.valM),
        .src_a (srcA),
        .src_b (srcB),
        .rd_a  (arr_a),
        .rd_b  (arr_b),
        .rsp   (reg_rsp)
    );

`ifdef WB_BYPASS_EN
    always_comb begin
        rd_valA = arr_a;
        rd_valB = arr_b;
        if (commit && is_reg(srcA)) begin
            if (srcA == w_q.dstM)      rd_valA = w_q.valM;
            else if (srcA == w_q.dstE) rd_valA = w_q.valE;
        end
        if (commit && is_reg(srcB)) begin
            if (srcB == w_q.dstM)      rd_valB = w_q.valM;
            else if (srcB == w_q.dstE) rd_valB = w_q.valE;
        end
    end
`else
    assign rd_valA = arr_a;
    assign rd_valB = arr_b;
`endif

    assign wb_stat     = w_q.stat;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_y86_writeback.sv
// Randomized self-checking bench for y86_writeback against a register-level
// behavioural model, plus directed irmovq/popq/stall/bypass/halt/fault scenarios.
module tb_y86_writeback;
    import y86_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            m_valid = 1'b0;
    logic [2:0]      m_stat = STAT_AOK;
    logic [3:0]      m_icode = INOP;
    logic [3:0]      m_dstE = RNONE;
    logic [63:0]     m_valE = '0;
    logic [3:0]      m_dstM = RNONE;
    logic [63:0]     m_valM = '0;
    logic            w_stall = 1'b0;
    logic            w_bubble = 1'b0;
    logic [3:0]      srcA = '0;
    logic [3:0]      srcB = '0;
    logic [63:0]     rd_valA, rd_valB, reg_rsp;
    logic [2:0]      wb_stat;
    logic [1:0]      cpu_state;
    logic [31:0]     retired_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    y86_writeback dut (
        .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_stat(m_stat), .m_icode(m_icode),
        .m_dstE(m_dstE), .m_valE(m_valE), .m_dstM(m_dstM), .m_valM(m_valM),
        .w_stall(w_stall), .w_bubble(w_bubble), .srcA(srcA), .srcB(srcB),
        .rd_valA(rd_valA), .rd_valB(rd_valB), .wb_stat(wb_stat), .cpu_state(cpu_state),
        .retired_cnt(retired_cnt), .reg_rsp(reg_rsp)
    );

    // Reference model: architectural registers, the one pending instruction, status, count
    logic [63:0] mr [15];
    logic        p_valid;
    logic [2:0]  p_stat;
    logic [3:0]  p_dE, p_dM;
    logic [63:0] p_vE, p_vM;
    int          mst;     // 0 run, 1 halted, 2 fault
    logic [31:0] mcnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) mr[i] = '0;
        p_valid = 0; p_stat = STAT_AOK; p_dE = RNONE; p_dM = RNONE; p_vE = '0; p_vM = '0;
        mst = 0; mcnt = '0;
    endtask

    // Value decode should see for a register right now.
    function automatic logic [63:0] mread(input logic [3:0] s);
        if (s >= 4'd15) return '0;
`ifdef WB_BYPASS_EN
        if (mst == 0 && p_valid && p_stat == STAT_AOK) begin
            if (p_dM == s) return p_vM;
            if (p_dE == s) return p_vE;
        end
`endif
        return mr[s];
    endfunction

    task automatic model_edge();
        if (mst != 0) return;
        if (p_valid && p_stat == STAT_AOK) begin
            if (p_dE < 4'd15) mr[p_dE] = p_vE;
            if (p_dM < 4'd15) mr[p_dM] = p_vM;
            mcnt = mcnt + 1;
        end
        if (p_valid && p_stat != STAT_AOK) begin
            mst = (p_stat == STAT_HLT) ? 1 : 2;
        end else if (!w_stall) begin
            if (w_bubble || !m_valid) begin
                p_valid = 0; p_stat = STAT_AOK; p_dE = RNONE; p_dM = RNONE; p_vE = '0; p_vM = '0;
            end else begin
                p_valid = 1; p_stat = m_stat; p_dE = m_dstE; p_dM = m_dstM; p_vE = m_valE; p_vM = m_valM;
            end
        end
    endtask

    task automatic check_all();
        chk("rd_valA", rd_valA, mread(srcA));
        chk("rd_valB", rd_valB, mread(srcB));
        chk("wb_stat", 64'(wb_stat), 64'(p_stat));
        chk("cpu_state", 64'(cpu_state), 64'(mst));
        chk("retired_cnt", 64'(retired_cnt), 64'(mcnt));
        chk("reg_rsp", reg_rsp, mr[4]);
    endtask

    // Called at a negedge; applies inputs, checks, crosses one rising edge, returns at the next negedge.
    task automatic drive(input logic v, input logic [2:0] st, input logic [3:0] ic,
                         input logic [3:0] dE, input logic [63:0] vE,
                         input logic [3:0] dM, input logic [63:0] vM,
                         input logic stall, input logic bub, input logic [3:0] sA, input logic [3:0] sB);
        m_valid = v; m_stat = st; m_icode = ic; m_dstE = dE; m_valE = vE;
        m_dstM = dM; m_valM = vM; w_stall = stall; w_bubble = bub; srcA = sA; srcB = sB;
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, STAT_AOK, INOP, RNONE, '0, RNONE, '0, 1'b0, 1'b0, 4'd0, 4'd4);
    endtask

    // Asynchronous reset pulse landing between clock edges.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk("rst_state", 64'(cpu_state), 64'(CPU_RUN));
        chk("rst_cnt", 64'(retired_cnt), 64'd0);
        chk("rst_wbstat", 64'(wb_stat), 64'(STAT_AOK));
        chk("rst_rsp", reg_rsp, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic peek(input logic [3:0] sA, input logic [3:0] sB);
        srcA = sA; srcB = sB;
        #1;
    endtask

    function automatic logic [2:0] rand_stat();
        int r;
        r = $urandom_range(0, 99);
        if (r < 94) return STAT_AOK;
        if (r < 96) return STAT_HLT;
        if (r < 98) return STAT_ADR;
        return STAT_INS;
    endfunction

    logic [31:0] cnt_at_halt;

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // irmovq $0x1234, %rax
        drive(1'b1, STAT_AOK, IIRMOVQ, 4'd0, 64'h1234, RNONE, '0, 1'b0, 1'b0, 4'd0, 4'd0);
        idle();
        peek(4'd0, 4'd15);
        chk("irmovq_rd", rd_valA, 64'h1234);
        chk("irmovq_cnt", 64'(retired_cnt), 64'd1);
        chk("rnone_rd", rd_valB, 64'd0);

        // popq %rsp: valM wins over valE
        drive(1'b1, STAT_AOK, IPOPQ, 4'd4, 64'h108, 4'd4, 64'hBEEF, 1'b0, 1'b0, 4'd4, 4'd0);
        idle();
        chk("popq_rsp", reg_rsp, 64'hBEEF);

        // Stall: held W recommits every edge, new m_* ignored until release
        drive(1'b1, STAT_AOK, IRRMOVQ, 4'd3, 64'h77, RNONE, '0, 1'b0, 1'b0, 4'd3, 4'd5);
        for (int i = 0; i < 3; i++)
            drive(1'b1, STAT_AOK, IOPQ, 4'd5, 64'h99, RNONE, '0, 1'b1, 1'b0, 4'd3, 4'd5);
        peek(4'd3, 4'd5);
        chk("stall_cnt", 64'(retired_cnt), 64'd5);
        chk("stall_r3", rd_valA, 64'h77);
        chk("stall_r5", rd_valB, 64'd0);
        drive(1'b1, STAT_AOK, IOPQ, 4'd5, 64'h99, RNONE, '0, 1'b0, 1'b0, 4'd3, 4'd5);
        idle();
        peek(4'd3, 4'd5);
        chk("release_r5", rd_valB, 64'h99);
        chk("release_cnt", 64'(retired_cnt), 64'd7);

        // Same-cycle read of a register being committed
        drive(1'b1, STAT_AOK, IIRMOVQ, 4'd2, 64'h55, RNONE, '0, 1'b0, 1'b0, 4'd0, 4'd2);
        peek(4'd0, 4'd2);
`ifdef WB_BYPASS_EN
        chk("bypass_rdB", rd_valB, 64'h55);
`else
        chk("bypass_rdB", rd_valB, 64'd0);
`endif
        idle();

        // halt: sticky, later AOK input neither writes nor counts
        drive(1'b1, STAT_HLT, IHALT, RNONE, '0, RNONE, '0, 1'b0, 1'b0, 4'd0, 4'd0);
        cnt_at_halt = mcnt;
        idle();
        for (int i = 0; i < 3; i++)
            drive(1'b1, STAT_AOK, IIRMOVQ, 4'd6, 64'hAB, RNONE, '0, 1'b0, 1'b0, 4'd6, 4'd0);
        peek(4'd6, 4'd0);
        chk("halt_state", 64'(cpu_state), 64'(CPU_HALTED));
        chk("halt_r6", rd_valA, 64'd0);
        chk("halt_cnt", 64'(retired_cnt), 64'(cnt_at_halt));

        // fault: reg1 not written, then reset clears everything
        do_reset();
        drive(1'b1, STAT_ADR, IMRMOVQ, 4'd1, 64'h5A, RNONE, '0, 1'b0, 1'b0, 4'd1, 4'd0);
        idle();
        idle();
        peek(4'd1, 4'd0);
        chk("fault_state", 64'(cpu_state), 64'(CPU_FAULT));
        chk("fault_r1", rd_valA, 64'd0);
        do_reset();
        peek(4'd1, 4'd0);
        chk("post_rst_r0", rd_valB, 64'd0);

        // Randomized segments, each ending in a mid-cycle reset
        for (int seg = 0; seg < 8; seg++) begin
            for (int c = 0; c < 150; c++) begin
                drive($urandom_range(0, 5) != 0, rand_stat(), 4'($urandom_range(0, 11)),
                      4'($urandom_range(0, 15)), {$urandom, $urandom},
                      ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : RNONE,
                      {$urandom, $urandom},
                      $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
            do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
